// File: rtl/mem_responder_if.sv
// Strobe-driven memory bus between the CPU (master) and the memory responder (slave),
// plus the program-load port used while the bus is idle.
interface mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              MAR_load;
    logic [ADDR_W-1:0] addr_in;
    logic              CS;
    logic              OE;
    logic              WE;
    logic              Bc;
    logic              Ac;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              bus_drive;
    logic              busy;
    logic              protocol_err;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output MAR_load, addr_in, CS, OE, WE, Bc, Ac, data_in,
        output prog_we, prog_addr, prog_data,
        input  data_out, data_out_valid, bus_drive, busy, protocol_err
    );

    modport slave (
        input  MAR_load, addr_in, CS, OE, WE, Bc, Ac, data_in,
        input  prog_we, prog_addr, prog_data,
        output data_out, data_out_valid, bus_drive, busy, protocol_err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: MAR, word-addressed RAM, active-low strobe decode into
// read/write cycles, idle-only program load and a registered protocol-error pulse.
module mem_responder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_READ   = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ac_seen_q, ac_seen_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_out_q;

    logic              rd_en;
    logic              mem_we;
    logic              mem_we_eff;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        mar_d     = bus.MAR_load ? bus.addr_in : mar_q;
        wdata_d   = wdata_q;
        ac_seen_d = ac_seen_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        rd_en     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = mar_q;
        mem_wdata = wdata_q;

        case (state_q)
            ST_IDLE, ST_SELECT: begin
                if (bus.CS) begin
                    state_d = ST_IDLE;
                end else if (!bus.OE && bus.WE) begin
                    state_d = ST_READ;
                end else if (bus.OE && !bus.WE) begin
                    state_d   = ST_WRITE;
                    ac_seen_d = 1'b0;
                end else if (bus.OE && bus.WE) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_SELECT;
                    err_d   = 1'b1;
                end
            end

            ST_READ: begin
                if (bus.CS) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (bus.OE) begin
                    state_d = ST_SELECT;
                    valid_d = 1'b0;
                end else begin
                    // data_out follows MAR every cycle so a mid-read MAR_load lands one edge later
                    rd_en   = 1'b1;
                    valid_d = 1'b1;
                end
            end

            ST_WRITE: begin
                if (bus.Ac) begin
                    wdata_d   = bus.data_in;
                    ac_seen_d = 1'b1;
                end
                if (bus.CS) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    if (!bus.OE) begin
                        err_d = 1'b1;
                    end
                    if (bus.WE) begin
                        state_d = ST_SELECT;
                        if (ac_seen_q || bus.Ac) begin
                            mem_we    = 1'b1;
                            mem_wdata = bus.Ac ? bus.data_in : wdata_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Program load shares the single write port; it can only win while the bus is idle.
        if (bus.prog_we) begin
            if (state_q == ST_IDLE && bus.CS) begin
                mem_we    = 1'b1;
                mem_waddr = bus.prog_addr;
                mem_wdata = bus.prog_data;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign mem_we_eff = mem_we && !reset;

    always_ff @(posedge clk) begin
        if (mem_we_eff) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mar_q      <= '0;
            wdata_q    <= '0;
            ac_seen_q  <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            wdata_q   <= wdata_d;
            ac_seen_q <= ac_seen_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            if (rd_en) begin
                data_out_q <= mem[mar_q];
            end
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = valid_q;
    assign bus.bus_drive      = (state_q == ST_READ) && valid_q && bus.Bc;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.protocol_err   = err_q;
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's strobe-driven memory bus. It holds the memory address register and a word-addressed RAM array. It decodes the CPU's active-low CS/OE/WE strobes into read and write cycles, and returns read data under bus-capture control. It also offers a program-load port that is usable only while the bus is idle, and it flags strobe-protocol violations.

## Interface
Parameters:
- DATA_W, 8, data word width
- ADDR_W, 5, address width; array depth is 2**ADDR_W words

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- MAR_load  in  1  capture addr_in into MAR this edge
- addr_in  in  ADDR_W  address from the IR/PC select mux
- CS  in  1  chip select, active low
- OE  in  1  output enable, active low
- WE  in  1  write enable, active low
- Bc  in  1  CPU requests memory to drive the bus (read capture)
- Ac  in  1  CPU is driving write data on data_in
- data_in  in  DATA_W  write data from the accumulator
- data_out  out  DATA_W  registered read data
- data_out_valid  out  1  data_out holds mem[MAR] for the current read cycle
- bus_drive  out  1  memory owns the bus; equals (state==READ) & data_out_valid & Bc
- busy  out  1  state != IDLE
- protocol_err  out  1  one-cycle pulse on a strobe violation
- prog_we  in  1  program-load write strobe, active high
- prog_addr  in  ADDR_W  program-load address
- prog_data  in  DATA_W  program-load data

## Operation
- MAR: on every edge with MAR_load=1, MAR <= addr_in. This happens in any state.
- States: IDLE, SELECT, READ, WRITE.
- Strobe decode (D), evaluated in IDLE and SELECT when CS=0:
  - OE=0, WE=1 -> READ.
  - WE=0, OE=1 -> WRITE; clear ac_seen.
  - OE=1, WE=1 -> SELECT.
  - OE=0, WE=0 -> SELECT, and pulse protocol_err.
- IDLE: CS=1 -> stay in IDLE. CS=0 -> apply D.
- SELECT: CS=1 -> IDLE. Otherwise apply D.
- READ:
  - Each edge: data_out <= mem[MAR] and data_out_valid <= 1.
  - Because data_out tracks MAR every cycle, an MAR_load during READ shows up on data_out after one edge.
  - OE=1 -> SELECT. CS=1 -> IDLE.
  - On exit, data_out_valid <= 0; data_out holds its last value.
- WRITE:
  - Each edge with Ac=1: wdata <= data_in and ac_seen <= 1.
  - WE returns to 1 while CS=0:
    - If ac_seen=1 (including an Ac=1 on that same edge), commit mem[MAR] <= the latest wdata (data_in if Ac=1 on that edge), then go to SELECT.
    - If ac_seen=0, make no write, pulse protocol_err, and go to SELECT.
  - CS=1 while WE=0: abort with no write, pulse protocol_err, and go to IDLE.
  - OE=0 while in WRITE: pulse protocol_err and stay in WRITE.
- Program load: on an edge with prog_we=1 and state==IDLE and CS=1, write mem[prog_addr] <= prog_data. prog_we in any other state or with CS=0 is ignored and pulses protocol_err.
- reset:
  - state <= IDLE; MAR <= 0; data_out <= 0; data_out_valid, protocol_err, ac_seen and wdata <= 0.
  - Array contents are NOT cleared.
  - A write cycle in progress when reset hits never commits.
- Address wrap: MAR is exactly ADDR_W bits, so there is no out-of-range condition.

## Timing
- Reset values: data_out=0, data_out_valid=0, bus_drive=0, busy=0, protocol_err=0.
- Read latency: if CS=0 and OE=0 are sampled at edge k, state=READ after k, and data_out/data_out_valid are set at edge k+1. bus_drive can assert after k+1 if Bc=1.
- A read with a same-edge MAR_load at edge k returns the new address's data at edge k+1, because MAR updates at k.
- Write commit happens at the edge where WE=1 is first sampled with CS=0. A read of the same address entering READ at that same edge returns the new data one edge later.
- protocol_err is high for exactly one cycle per violation. It is registered and asserts the cycle after the offending edge.
- busy is combinational from state.

## Test plan
- Program-load then read:
  - Stimulus: prog_we writes 0x3C to address 5. Then MAR_load with addr_in=5, then CS=0 and OE=0.
  - Required: data_out=0x3C and data_out_valid=1 exactly 1 edge after READ is entered. With Bc=1, bus_drive=1.
- Bus write:
  - Stimulus: MAR=0x1F. CS=0, WE=0, Ac=1 with data_in=0xA5 for 2 cycles, then WE=1.
  - Required: mem[0x1F]=0xA5. A subsequent read of 0x1F returns 0xA5 and wrap addressing is correct.
- Aborted write:
  - Stimulus: WE=0, Ac=1 with data_in=0x77, then CS=1 while WE is still 0.
  - Required: protocol_err pulses once, mem is unchanged, state=IDLE.
- Write without Ac:
  - Stimulus: a WE pulse with Ac held at 0.
  - Required: no write, protocol_err pulses once.
- Reset mid-operation:
  - Stimulus: assert reset during WRITE (Ac=1, data_in=0x11), and separately during READ.
  - Required: no commit. All outputs are 0 the next cycle, and previously stored words remain intact.
- Illegal strobes:
  - Stimulus: CS=0 with OE=0 and WE=0; separately, prog_we=1 while busy=1.
  - Required: each produces a single protocol_err pulse and no array change.
